// File: rtl/load_store_unit.sv
// Data-memory access stage: one dmem handshake per load/store, load extension,
// pipeline stall while outstanding, misalignment and bus-timeout flags.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        mem_op_valid_in,
    input  logic        mem_is_store_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] iadder_out_in,
    input  logic [31:0] rs2_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_be_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] lu_output_out,
    output logic        lu_valid_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] tmo_cnt;

    // Captured op attributes needed at completion
    logic             op_store;
    logic [2:0]       op_funct3;
    logic [1:0]       op_off;

    logic             legal;
    logic             aligned;
    logic             accept;
    logic             expire;
    logic [31:0]      wdata_next;
    logic [3:0]       be_next;
    logic [31:0]      lane;
    logic [31:0]      lu_next;

    // Decode legality and alignment of the presented op
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b0;
        if (mem_is_store_in) begin
            legal = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010);
        end else begin
            legal = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                    (funct3_in == 3'b100) || (funct3_in == 3'b101);
        end
        case (funct3_in[1:0])
            2'b01:   aligned = ~iadder_out_in[0];
            2'b10:   aligned = (iadder_out_in[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign accept    = (state == IDLE) && mem_op_valid_in && legal && aligned;
    assign expire    = (state == BUSY) && !dmem_ack_in && (tmo_cnt == CNT_LAST);
    assign stall_out = accept || ((state == BUSY) && !dmem_ack_in);

    // Store lane replication and byte enables by access size
    always_comb begin
        wdata_next = rs2_in;
        be_next    = 4'b1111;
        case (funct3_in[1:0])
            2'b00: begin
                wdata_next = {4{rs2_in[7:0]}};
                be_next    = 4'b0001 << iadder_out_in[1:0];
            end
            2'b01: begin
                wdata_next = {2{rs2_in[15:0]}};
                be_next    = iadder_out_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_next = rs2_in;
                be_next    = 4'b1111;
            end
        endcase
    end

    // Load result extraction from the addressed byte lane
    always_comb begin
        lane    = dmem_rdata_in >> {op_off, 3'b000};
        lu_next = lane;
        case (op_funct3)
            3'b000:  lu_next = {{24{lane[7]}}, lane[7:0]};
            3'b100:  lu_next = {24'h0, lane[7:0]};
            3'b001:  lu_next = {{16{lane[15]}}, lane[15:0]};
            3'b101:  lu_next = {16'h0, lane[15:0]};
            default: lu_next = lane;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack_in || expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered bus outputs, completion pulses and timeout counter
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            tmo_cnt        <= '0;
            op_store       <= 1'b0;
            op_funct3      <= 3'b000;
            op_off         <= 2'b00;
            dmem_req_out   <= 1'b0;
            dmem_we_out    <= 1'b0;
            dmem_addr_out  <= '0;
            dmem_wdata_out <= '0;
            dmem_be_out    <= '0;
            lu_output_out  <= '0;
            lu_valid_out   <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
        end else begin
            lu_valid_out   <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            if (state == IDLE) begin
                if (mem_op_valid_in && legal && !aligned) begin
                    misaligned_out <= 1'b1;
                end
                if (accept) begin
                    tmo_cnt        <= '0;
                    op_store       <= mem_is_store_in;
                    op_funct3      <= funct3_in;
                    op_off         <= iadder_out_in[1:0];
                    dmem_req_out   <= 1'b1;
                    dmem_we_out    <= mem_is_store_in;
                    dmem_addr_out  <= {iadder_out_in[31:2], 2'b00};
                    dmem_wdata_out <= wdata_next;
                    dmem_be_out    <= be_next;
                end
            end else begin
                if (dmem_ack_in) begin
                    dmem_req_out <= 1'b0;
                    if (!op_store) begin
                        lu_output_out <= lu_next;
                        lu_valid_out  <= 1'b1;
                    end
                end else if (expire) begin
                    dmem_req_out  <= 1'b0;
                    bus_error_out <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: load extension, store lanes, misalignment,
// illegal ops, back-to-back issue, timeout, ack at expiry and mid-op reset.
module tb_load_store_unit;

    localparam int unsigned TMO = 255;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        mem_op_valid_in;
    logic        mem_is_store_in;
    logic [2:0]  funct3_in;
    logic [31:0] iadder_out_in;
    logic [31:0] rs2_in;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_be_out;
    logic        dmem_ack_in;
    logic [31:0] dmem_rdata_in;
    logic [31:0] lu_output_out;
    logic        lu_valid_out;
    logic        stall_out;
    logic        misaligned_out;
    logic        bus_error_out;

    int n_vec = 0;
    int n_bad = 0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .mem_op_valid_in (mem_op_valid_in),
        .mem_is_store_in (mem_is_store_in),
        .funct3_in       (funct3_in),
        .iadder_out_in   (iadder_out_in),
        .rs2_in          (rs2_in),
        .dmem_req_out    (dmem_req_out),
        .dmem_we_out     (dmem_we_out),
        .dmem_addr_out   (dmem_addr_out),
        .dmem_wdata_out  (dmem_wdata_out),
        .dmem_be_out     (dmem_be_out),
        .dmem_ack_in     (dmem_ack_in),
        .dmem_rdata_in   (dmem_rdata_in),
        .lu_output_out   (lu_output_out),
        .lu_valid_out    (lu_valid_out),
        .stall_out       (stall_out),
        .misaligned_out  (misaligned_out),
        .bus_error_out   (bus_error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Present one op for a cycle; leaves the bench just after the accepting edge
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_stall, input string tag);
        mem_op_valid_in = 1'b1;
        mem_is_store_in = st;
        funct3_in       = f3;
        iadder_out_in   = a;
        rs2_in          = d;
        #1;
        chk({tag, "_stall0"}, 32'(stall_out), 32'(exp_stall));
        step();
        mem_op_valid_in = 1'b0;
    endtask

    // Ack in the current cycle, then move past the completing edge
    task automatic ack_now(input logic [31:0] rd);
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = rd;
        step();
        dmem_ack_in   = 1'b0;
        dmem_rdata_in = 32'h0;
    endtask

    initial begin
        int n;
        reset_in        = 1'b1;
        mem_op_valid_in = 1'b0;
        mem_is_store_in = 1'b0;
        funct3_in       = 3'b000;
        iadder_out_in   = 32'h0;
        rs2_in          = 32'h0;
        dmem_ack_in     = 1'b0;
        dmem_rdata_in   = 32'h0;
        step();
        step();
        chk("rst_req",   32'(dmem_req_out), 32'd0);
        chk("rst_we",    32'(dmem_we_out), 32'd0);
        chk("rst_addr",  dmem_addr_out, 32'h0);
        chk("rst_wdata", dmem_wdata_out, 32'h0);
        chk("rst_be",    32'(dmem_be_out), 32'h0);
        chk("rst_lu",    lu_output_out, 32'h0);
        chk("rst_luv",   32'(lu_valid_out), 32'd0);
        chk("rst_mis",   32'(misaligned_out), 32'd0);
        chk("rst_berr",  32'(bus_error_out), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        reset_in = 1'b0;
        step();

        // LB at 0x103: top byte 0x80 sign-extended
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1, "lb");
        chk("lb_req",  32'(dmem_req_out), 32'd1);
        chk("lb_we",   32'(dmem_we_out), 32'd0);
        chk("lb_addr", dmem_addr_out, 32'h0000_0100);
        chk("lb_be",   32'(dmem_be_out), 32'h8);
        chk("lb_stall_busy", 32'(stall_out), 32'd1);
        dmem_ack_in = 1'b1;
        #1;
        chk("lb_stall_ack", 32'(stall_out), 32'd0);
        dmem_ack_in = 1'b0;
        ack_now(32'h80AA_BBCC);
        chk("lb_luv",   32'(lu_valid_out), 32'd1);
        chk("lb_lu",    lu_output_out, 32'hFFFF_FF80);
        chk("lb_req_drop", 32'(dmem_req_out), 32'd0);
        chk("lb_stall_done", 32'(stall_out), 32'd0);
        step();
        chk("lb_luv_pulse", 32'(lu_valid_out), 32'd0);
        chk("lb_lu_hold",   lu_output_out, 32'hFFFF_FF80);

        // LHU / LH at 0x202 on upper half 0x8001
        issue(1'b0, 3'b101, 32'h0000_0202, 32'h0, 1'b1, "lhu");
        chk("lhu_be", 32'(dmem_be_out), 32'hC);
        ack_now(32'h8001_1234);
        chk("lhu_lu", lu_output_out, 32'h0000_8001);
        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0, 1'b1, "lh");
        ack_now(32'h8001_1234);
        chk("lh_lu", lu_output_out, 32'hFFFF_8001);

        // LBU at 0x101: byte 1 = 0xF7 zero-extended
        issue(1'b0, 3'b100, 32'h0000_0101, 32'h0, 1'b1, "lbu");
        ack_now(32'h0000_F700);
        chk("lbu_lu", lu_output_out, 32'h0000_00F7);

        // SB at 0x301
        issue(1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 1'b1, "sb");
        chk("sb_req",   32'(dmem_req_out), 32'd1);
        chk("sb_we",    32'(dmem_we_out), 32'd1);
        chk("sb_addr",  dmem_addr_out, 32'h0000_0300);
        chk("sb_wdata", dmem_wdata_out, 32'hA5A5_A5A5);
        chk("sb_be",    32'(dmem_be_out), 32'h2);
        step();
        chk("sb_hold_wdata", dmem_wdata_out, 32'hA5A5_A5A5);
        ack_now(32'hFFFF_FFFF);
        chk("sb_luv", 32'(lu_valid_out), 32'd0);
        chk("sb_lu",  lu_output_out, 32'h0000_00F7);
        step();

        // LW at 0x402 is misaligned
        issue(1'b0, 3'b010, 32'h0000_0402, 32'h0, 1'b0, "lw_mis");
        chk("lw_mis_flag", 32'(misaligned_out), 32'd1);
        chk("lw_mis_req",  32'(dmem_req_out), 32'd0);
        step();
        chk("lw_mis_pulse", 32'(misaligned_out), 32'd0);

        // Illegal funct3 ignored
        issue(1'b0, 3'b011, 32'h0000_0401, 32'h0, 1'b0, "ill_ld");
        chk("ill_ld_req", 32'(dmem_req_out), 32'd0);
        chk("ill_ld_mis", 32'(misaligned_out), 32'd0);
        issue(1'b1, 3'b100, 32'h0000_0400, 32'h0, 1'b0, "ill_st");
        chk("ill_st_req", 32'(dmem_req_out), 32'd0);

        // SH at 0x506, then back-to-back LW in the cycle req drops
        issue(1'b1, 3'b001, 32'h0000_0506, 32'hCAFE_BEEF, 1'b1, "sh");
        chk("sh_addr",  dmem_addr_out, 32'h0000_0504);
        chk("sh_wdata", dmem_wdata_out, 32'hBEEF_BEEF);
        chk("sh_be",    32'(dmem_be_out), 32'hC);
        ack_now(32'h0);
        chk("b2b_req_drop", 32'(dmem_req_out), 32'd0);
        issue(1'b0, 3'b010, 32'h0000_0600, 32'h0, 1'b1, "b2b");
        chk("b2b_req",  32'(dmem_req_out), 32'd1);
        chk("b2b_addr", dmem_addr_out, 32'h0000_0600);
        chk("b2b_be",   32'(dmem_be_out), 32'hF);
        ack_now(32'h1122_3344);
        chk("b2b_lu", lu_output_out, 32'h1122_3344);

        // Ack in IDLE is ignored
        ack_now(32'h5555_5555);
        chk("idle_ack_luv", 32'(lu_valid_out), 32'd0);
        chk("idle_ack_lu",  lu_output_out, 32'h1122_3344);

        // Timeout: req held exactly TMO cycles, then bus error
        issue(1'b0, 3'b010, 32'h0000_0700, 32'h0, 1'b1, "tmo");
        n = 0;
        while (dmem_req_out && n < 300) begin
            n++;
            step();
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_berr",   32'(bus_error_out), 32'd1);
        chk("tmo_luv",    32'(lu_valid_out), 32'd0);
        chk("tmo_lu",     lu_output_out, 32'h1122_3344);
        step();
        chk("tmo_berr_pulse", 32'(bus_error_out), 32'd0);

        // Ack in the expiry cycle completes normally
        issue(1'b0, 3'b010, 32'h0000_0704, 32'h0, 1'b1, "exp");
        for (int i = 0; i < int'(TMO) - 1; i++) begin
            step();
        end
        chk("exp_req_last", 32'(dmem_req_out), 32'd1);
        ack_now(32'hDEAD_BEEF);
        chk("exp_berr", 32'(bus_error_out), 32'd0);
        chk("exp_luv",  32'(lu_valid_out), 32'd1);
        chk("exp_lu",   lu_output_out, 32'hDEAD_BEEF);

        // Reset mid-BUSY abandons the op; later ack ignored
        issue(1'b1, 3'b010, 32'h0000_0800, 32'h9876_5432, 1'b1, "rmid");
        step();
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        chk("rmid_req",   32'(dmem_req_out), 32'd0);
        chk("rmid_we",    32'(dmem_we_out), 32'd0);
        chk("rmid_wdata", dmem_wdata_out, 32'h0);
        chk("rmid_lu",    lu_output_out, 32'h0);
        chk("rmid_luv",   32'(lu_valid_out), 32'd0);
        chk("rmid_berr",  32'(bus_error_out), 32'd0);
        step();
        step();
        ack_now(32'h7777_7777);
        chk("rmid_ack_luv",  32'(lu_valid_out), 32'd0);
        chk("rmid_ack_lu",   lu_output_out, 32'h0);
        chk("rmid_ack_req",  32'(dmem_req_out), 32'd0);
        chk("rmid_ack_berr", 32'(bus_error_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
